// File: rtl/float_pkg.sv
// Shared types and constants for the floating-point adder front end.
package float_pkg;

  localparam int unsigned N         = 24;
  localparam int unsigned EXP       = 8;
  localparam int unsigned SHIFT_MAX = N + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } align_state_t;

  // effExp already has exponent 0 promoted to 1; mant carries the hidden bit.
  typedef struct packed {
    logic           sign;
    logic [EXP-1:0] effExp;
    logic [N-1:0]   mant;
  } unpacked_t;

endpackage

// File: rtl/float_unpack.sv
// Splits a packed operand into sign, effective exponent and mantissa with the
// hidden bit restored; flags an all-ones exponent (Inf/NaN).
module float_unpack
  import float_pkg::*;
#(
  parameter int unsigned n   = N,
  parameter int unsigned exp = EXP
) (
  input  logic [exp+n-1:0] word_i,
  output unpacked_t        unp_o,
  output logic             special_o
);

  logic [exp-1:0] rawExp;
  logic           hidden;

  assign rawExp = word_i[exp+n-2 -: exp];
  assign hidden = |rawExp;

  always_comb begin
    unp_o        = '0;
    unp_o.sign   = word_i[exp+n-1];
    unp_o.effExp = hidden ? rawExp : exp'(1);
    unp_o.mant   = {hidden, word_i[n-2:0]};
    special_o    = &rawExp;
  end

endmodule

// File: rtl/float_align.sv
// Operand alignment stage: orders two operands by magnitude and right-shifts
// the smaller mantissa one bit per cycle, producing R/S and compare flags.
module float_align
  import float_pkg::*;
#(
  parameter int unsigned n   = N,
  parameter int unsigned exp = EXP
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [exp+n-1:0] opA,
  input  logic [exp+n-1:0] opB,
  input  logic             inValid,
  output logic             inReady,
  output logic [n-1:0]     bigMant,
  output logic [n-1:0]     alignMant,
  output logic [exp-1:0]   alignExp,
  output logic             R,
  output logic             S,
  output logic             signOut,
  output logic             subCtrl,
  output logic             expNoDif,
  output logic             mantNoDif,
  output logic             special,
  output logic             outValid,
  input  logic             outReady
);

  localparam int unsigned CW = $clog2(n + 2);

  unpacked_t    ua, ub, big_d, small_d;
  logic         specA, specB;
  logic         aBig_d, accept;
  logic [exp:0] diff_d;
  logic [CW-1:0] k_d;

  align_state_t  state_q;
  logic [CW-1:0] k_q;
  logic [n-1:0]  bigMant_q, alignMant_q;
  logic [exp-1:0] alignExp_q;
  logic R_q, S_q, signOut_q, subCtrl_q, expNoDif_q, mantNoDif_q, special_q, outValid_q;

  float_unpack #(.n(n), .exp(exp)) u_unpack_a (.word_i(opA), .unp_o(ua), .special_o(specA));
  float_unpack #(.n(n), .exp(exp)) u_unpack_b (.word_i(opB), .unp_o(ub), .special_o(specB));

  assign inReady = (state_q == IDLE) && !Reset;
  assign accept  = inValid && inReady;

  // Ordering first keeps the exponent difference non-negative.
  always_comb begin
    aBig_d  = {ua.effExp, ua.mant} >= {ub.effExp, ub.mant};
    big_d   = aBig_d ? ua : ub;
    small_d = aBig_d ? ub : ua;
    diff_d  = {1'b0, big_d.effExp} - {1'b0, small_d.effExp};
    if (specA || specB)
      k_d = '0;
    else if (diff_d > (exp+1)'(n + 1))
      k_d = CW'(n + 1);
    else
      k_d = diff_d[CW-1:0];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      bigMant_q   <= '0;
      alignMant_q <= '0;
      alignExp_q  <= '0;
      R_q         <= 1'b0;
      S_q         <= 1'b0;
      signOut_q   <= 1'b0;
      subCtrl_q   <= 1'b0;
      expNoDif_q  <= 1'b0;
      mantNoDif_q <= 1'b0;
      special_q   <= 1'b0;
      outValid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          bigMant_q   <= big_d.mant;
          alignMant_q <= small_d.mant;
          alignExp_q  <= big_d.effExp;
          R_q         <= 1'b0;
          S_q         <= 1'b0;
          signOut_q   <= big_d.sign;
          subCtrl_q   <= ua.sign ^ ub.sign;
          expNoDif_q  <= opA[exp+n-2 -: exp] == opB[exp+n-2 -: exp];
          mantNoDif_q <= opA[n-2:0] == opB[n-2:0];
          special_q   <= specA || specB;
          k_q         <= k_d;
          if (k_d == '0) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
          end else begin
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          alignMant_q <= alignMant_q >> 1;
          R_q         <= alignMant_q[0];
          S_q         <= S_q | R_q;
          k_q         <= k_q - CW'(1);
          if (k_q == CW'(1)) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
          end
        end
        DONE: if (outReady) begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bigMant   = bigMant_q;
  assign alignMant = alignMant_q;
  assign alignExp  = alignExp_q;
  assign R         = R_q;
  assign S         = S_q;
  assign signOut   = signOut_q;
  assign subCtrl   = subCtrl_q;
  assign expNoDif  = expNoDif_q;
  assign mantNoDif = mantNoDif_q;
  assign special   = special_q;
  assign outValid  = outValid_q;

endmodule
